// File: rtl/iter_div.sv
// iter_div: unsigned restoring shift-subtract divider
// one quotient bit per cycle, go/busy/done handshake
module iter_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // dividend shifts out of the top while quotient bits fill the bottom
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_res_rem;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_dq_nxt;
  logic             w_ge;
  logic             w_last;
  logic             w_start;

  // partial remainder is WIDTH+1 bits wide only at the compare
  assign w_shift   = {r_rem, r_dq[WIDTH-1]};
  assign w_ge      = w_shift >= {1'b0, r_div};
  // when w_ge holds the true difference fits in WIDTH bits
  assign w_sub     = w_shift[WIDTH-1:0] - r_div;
  assign w_rem_nxt = w_ge ? w_sub : w_shift[WIDTH-1:0];
  assign w_dq_nxt  = {r_dq[WIDTH-2:0], w_ge};
  assign w_last    = (r_cnt == '0);
  assign w_start   = go && (r_state != CALC);

  assign quotient  = r_quo;
  assign remainder = r_res_rem;

  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (go) w_state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = go ? CALC : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // datapath: load on accepted go, iterate in CALC, publish on last step
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dq      <= '0;
      r_div     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_quo     <= '0;
      r_res_rem <= '0;
    end else if (w_start) begin
      r_dq  <= left;
      r_div <= right;
      r_rem <= '0;
      r_cnt <= CW'(WIDTH - 1);
    end else if (r_state == CALC) begin
      r_dq  <= w_dq_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_quo     <= w_dq_nxt;
        r_res_rem <= w_rem_nxt;
      end
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div: scoreboard bench for iter_div
// WIDTH=8 directed cases plus WIDTH=32 random sweep
module tb_iter_div;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  logic        rst8, g8, d8, b8;
  logic [7:0]  l8, r8, quo8, rem8;
  logic        rst32, g32, d32, b32;
  logic [31:0] l32, r32, quo32, rem32;

  exp_t        q8[$];
  exp_t        q32[$];
  exp_t        e8, e32;

  iter_div #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst8), .go(g8),
    .left(l8), .right(r8),
    .quotient(quo8), .remainder(rem8),
    .done(d8), .busy(b8)
  );

  iter_div #(.WIDTH(32)) u32 (
    .clk(clk), .reset(rst32), .go(g32),
    .left(l32), .right(r32),
    .quotient(quo32), .remainder(rem32),
    .done(d32), .busy(b32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (d8) begin
      if (q8.size() == 0) begin
        check("spurious_done8", 32'(d8), 32'd0);
      end else begin
        e8 = q8.pop_front();
        check("quo8", 32'(quo8), e8.q);
        check("rem8", 32'(rem8), e8.r);
        check("lat8", 32'(cyc - e8.c), 32'd9);
      end
    end
  end

  always @(negedge clk) begin
    if (d32) begin
      if (q32.size() == 0) begin
        check("spurious_done32", 32'(d32), 32'd0);
      end else begin
        e32 = q32.pop_front();
        check("quo32", quo32, e32.q);
        check("rem32", rem32, e32.r);
        check("lat32", 32'(cyc - e32.c), 32'd33);
      end
    end
  end

  function automatic exp_t model(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic [31:0] ones);
    exp_t x;
    if (b == 0) begin
      x.q = ones;
      x.r = a;
    end else begin
      x.q = a / b;
      x.r = a % b;
    end
    x.c = cyc;
    return x;
  endfunction

  task automatic push8(input logic [7:0] a, input logic [7:0] b);
    q8.push_back(model(32'(a), 32'(b), 32'hFF));
  endtask

  task automatic go8(input logic [7:0] a, input logic [7:0] b,
                     input bit push);
    g8 = 1'b1;
    l8 = a;
    r8 = b;
    if (push) push8(a, b);
    @(posedge clk); #1;
    g8 = 1'b0;
  endtask

  task automatic wait_done8(output int nbusy);
    bit seen;
    seen  = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b8) nbusy++;
      if (d8) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("timeout8", 32'd0, 32'd1);
  endtask

  task automatic go32(input logic [31:0] a, input logic [31:0] b);
    g32 = 1'b1;
    l32 = a;
    r32 = b;
    q32.push_back(model(a, b, 32'hFFFF_FFFF));
    @(posedge clk); #1;
    g32 = 1'b0;
  endtask

  task automatic wait_done32();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (d32) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("timeout32", 32'd0, 32'd1);
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return 32'd0;
    if (s == 1) return 32'd1;
    if (s == 2) return 32'hFFFF_FFFF;
    if (s == 3) return 32'($urandom_range(0, 255));
    return $urandom;
  endfunction

  logic [31:0] cor [3];
  int          nb;

  initial begin
    cor[0] = 32'd0;
    cor[1] = 32'd1;
    cor[2] = 32'hFFFF_FFFF;
    rst8  = 1'b1;
    rst32 = 1'b1;
    g8    = 1'b0;
    g32   = 1'b0;
    l8    = '0;
    r8    = '0;
    l32   = '0;
    r32   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_quo", 32'(quo8), 32'd0);
    check("rst_rem", 32'(rem8), 32'd0);
    check("rst_done", 32'(d8), 32'd0);
    check("rst_busy", 32'(b8), 32'd0);
    check("rst_quo32", quo32, 32'd0);
    realign();
    rst8  = 1'b0;
    rst32 = 1'b0;
    realign();

    go8(8'd100, 8'd7, 1'b1);
    wait_done8(nb);
    check("busy_len", 32'(nb), 32'd8);
    realign();

    go8(8'd5, 8'd0, 1'b1);
    wait_done8(nb);
    realign();
    go8(8'd255, 8'd1, 1'b1);
    wait_done8(nb);
    realign();
    go8(8'd3, 8'd10, 1'b1);
    wait_done8(nb);
    realign();

    go8(8'd200, 8'd3, 1'b1);
    realign();
    go8(8'd9, 8'd9, 1'b0);
    wait_done8(nb);
    realign();
    repeat (12) realign();

    go8(8'd200, 8'd3, 1'b1);
    wait_done8(nb);
    g8 = 1'b1;
    l8 = 8'd250;
    r8 = 8'd16;
    push8(8'd250, 8'd16);
    realign();
    g8 = 1'b0;
    repeat (4) @(negedge clk);
    check("hold_quo", 32'(quo8), 32'd66);
    check("hold_rem", 32'(rem8), 32'd2);
    check("hold_busy", 32'(b8), 32'd1);
    wait_done8(nb);
    realign();

    go8(8'd77, 8'd5, 1'b0);
    repeat (3) realign();
    rst8 = 1'b1;
    realign();
    rst8 = 1'b0;
    @(negedge clk);
    check("abort_quo", 32'(quo8), 32'd0);
    check("abort_rem", 32'(rem8), 32'd0);
    check("abort_done", 32'(d8), 32'd0);
    check("abort_busy", 32'(b8), 32'd0);
    repeat (12) realign();
    go8(8'd77, 8'd5, 1'b1);
    wait_done8(nb);
    realign();

    rst8 = 1'b1;
    go8(8'd9, 8'd2, 1'b0);
    rst8 = 1'b0;
    @(negedge clk);
    check("rstgo_busy", 32'(b8), 32'd0);
    repeat (12) realign();

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b;
      if (i < 9) begin
        a = cor[i / 3];
        b = cor[i % 3];
      end else begin
        a = pick();
        b = pick();
      end
      go32(a, b);
      wait_done32();
      realign();
    end

    repeat (3) realign();
    check("drain8", 32'(q8.size()), 32'd0);
    check("drain32", 32'(q32.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
